// File: rtl/mdu_unit_pkg.sv
// ============================================================================
// Module : mdu_unit_pkg
// Brief  : Shared MDU operation encodings, default latencies and helpers.
//          Optional macro MDU_MADD_EN enables the madd/msub family.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mdu_unit_pkg;

   typedef enum logic [3:0] {
      MDU_NONE = 4'd0,
      MULT     = 4'd1,
      MULTU    = 4'd2,
      DIV      = 4'd3,
      DIVU     = 4'd4,
      MFHI     = 4'd5,
      MFLO     = 4'd6,
      MTHI     = 4'd7,
      MTLO     = 4'd8,
      MADD     = 4'd9,
      MADDU    = 4'd10,
      MSUB     = 4'd11,
      MSUBU    = 4'd12
   } mdu_op_e;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } hilo_t;

   localparam int MUL_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF = 10;

   // Instruction-type tag the decode/stall logic uses to mark MDU instructions.
   localparam logic [3:0] ITYPE_MDU = 4'd6;

   function automatic logic is_start_op(input logic [3:0] op);
      case (op)
         MULT, MULTU, DIV, DIVU: return 1'b1;
`ifdef MDU_MADD_EN
         MADD, MADDU, MSUB, MSUBU: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == DIV) || (op == DIVU);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_unit_arith.sv
// ============================================================================
// Module : mdu_arith
// Brief  : Combinational 64-bit multiply/divide (and MDU_MADD_EN accumulate).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_arith
   import mdu_unit_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
`ifdef MDU_MADD_EN
   input  hilo_t       acc,
`endif
   output hilo_t       result,
   output logic        div_zero
);

   logic [63:0] a_sx, b_sx, prod_s, prod_u;
   logic [31:0] b_safe, a_mag, b_mag, b_mag_safe;
   logic [31:0] q_u, r_u, q_mag, r_mag;

   assign a_sx   = {{32{a[31]}}, a};
   assign b_sx   = {{32{b[31]}}, b};
   assign prod_s = a_sx * b_sx;
   assign prod_u = {32'd0, a} * {32'd0, b};

   // Signed division runs on magnitudes so 0x80000000 / -1 wraps cleanly.
   assign a_mag      = a[31] ? (32'd0 - a) : a;
   assign b_mag      = b[31] ? (32'd0 - b) : b;
   assign b_safe     = (b == 32'd0) ? 32'd1 : b;
   assign b_mag_safe = (b == 32'd0) ? 32'd1 : b_mag;
   assign q_u        = a / b_safe;
   assign r_u        = a % b_safe;
   assign q_mag      = a_mag / b_mag_safe;
   assign r_mag      = a_mag % b_mag_safe;

   assign div_zero = is_div_op(op) && (b == 32'd0);

   always_comb begin
      result = '0;
      case (op)
         MULT:  result = prod_s;
         MULTU: result = prod_u;
         DIV: begin
            result.lo = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
            result.hi = a[31] ? (32'd0 - r_mag) : r_mag;
         end
         DIVU: begin
            result.lo = q_u;
            result.hi = r_u;
         end
`ifdef MDU_MADD_EN
         MADD:  result = acc + prod_s;
         MADDU: result = acc + prod_u;
         MSUB:  result = acc - prod_s;
         MSUBU: result = acc - prod_u;
`endif
         default: result = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mdu_unit.sv
// ============================================================================
// Module : mdu_unit
// Brief  : E-stage multiply/divide unit with HI/LO, fixed-latency Busy count.
//          Optional macro MDU_MADD_EN enables madd/maddu/msub/msubu.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_unit
   import mdu_unit_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int DIV_CYCLES = DIV_CYCLES_DEF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [3:0]  MduOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] Out
);

   localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES);
   localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [CW-1:0] count;
   logic [0:0]    state;
   hilo_t         pending;
   logic          pending_ok;
   logic [31:0]   hi_q, lo_q;
   hilo_t         arith_res;
   logic          div_zero;
   logic          start_ok;

   mdu_arith u_arith (
      .op       (MduOp),
      .a        (A),
      .b        (B),
`ifdef MDU_MADD_EN
      .acc      ({hi_q, lo_q}),
`endif
      .result   (arith_res),
      .div_zero (div_zero)
   );

   assign state    = (count != '0) ? ST_RUN : ST_IDLE;
   assign start_ok = Start && (state == ST_IDLE) && is_start_op(MduOp);
   assign Busy     = Start | (count != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         count      <= '0;
         pending    <= '0;
         pending_ok <= 1'b0;
         hi_q       <= 32'd0;
         lo_q       <= 32'd0;
      end else begin
         assert (!(Start && (state == ST_IDLE)) || is_start_op(MduOp))
            else $warning("mdu_unit: Start with non-start MduOp %0d ignored", MduOp);
         case (state)
            ST_IDLE: begin
               if (start_ok) begin
                  pending    <= arith_res;
                  pending_ok <= !div_zero;
                  count      <= is_div_op(MduOp) ? DIV_LOAD : MUL_LOAD;
               end else if (!Start && (MduOp == MTHI)) begin
                  hi_q <= A;
               end else if (!Start && (MduOp == MTLO)) begin
                  lo_q <= A;
               end
            end
            ST_RUN: begin
               // Writeback happens on the same edge the counter reaches zero.
               count <= count - CNT_ONE;
               if ((count == CNT_ONE) && pending_ok) begin
                  hi_q <= pending.hi;
                  lo_q <= pending.lo;
               end
            end
            default: count <= '0;
         endcase
      end
   end

   assign HI = hi_q;
   assign LO = lo_q;

   always_comb begin
      Out = 32'd0;
      case (MduOp)
         MFHI:    Out = hi_q;
         MFLO:    Out = lo_q;
         default: Out = 32'd0;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_mdu_unit.sv
// ============================================================================
// Module : tb_mdu_unit
// Brief  : Scoreboard bench for mdu_unit against an arithmetic HI/LO model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mdu_unit;
   import mdu_unit_pkg::*;

   localparam int MULN = 5;
   localparam int DIVN = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        Start = 1'b0;
   logic [3:0]  MduOp = MDU_NONE;
   logic [31:0] A = 32'd0;
   logic [31:0] B = 32'd0;
   logic        Busy;
   logic [31:0] HI, LO, Out;

   mdu_unit #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
      .clk   (clk),
      .reset (reset),
      .Start (Start),
      .MduOp (MduOp),
      .A     (A),
      .B     (B),
      .Busy  (Busy),
      .HI    (HI),
      .LO    (LO),
      .Out   (Out)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] out_q[$];
   int          len_q[$];
   logic [63:0] m_hilo = 64'd0;
   logic [63:0] held   = 64'd0;
   bit          mon_en = 1'b0;
   int          run_len = 0;

   task automatic fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Architectural model: HI/LO after one op, plus the Busy episode length.
   function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [63:0] hl, output int blen);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      blen = 1;
      case (op)
         MULT:  begin hl = sa * sb; blen = MULN + 1; end
         MULTU: begin hl = {32'd0, a} * {32'd0, b}; blen = MULN + 1; end
         DIV: begin
            if (b != 0) hl = {32'(sa % sb), 32'(sa / sb)};
            blen = DIVN + 1;
         end
         DIVU: begin
            if (b != 0) hl = {a % b, a / b};
            blen = DIVN + 1;
         end
`ifdef MDU_MADD_EN
         MADD:  begin hl = hl + (sa * sb); blen = MULN + 1; end
         MADDU: begin hl = hl + ({32'd0, a} * {32'd0, b}); blen = MULN + 1; end
         MSUB:  begin hl = hl - (sa * sb); blen = MULN + 1; end
         MSUBU: begin hl = hl - ({32'd0, a} * {32'd0, b}); blen = MULN + 1; end
`endif
         default: blen = 1;
      endcase
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         if (MduOp == MFHI || MduOp == MFLO) begin
            if (out_q.size() == 0) fail("unexpected_read");
            else check("out_read", {32'd0, Out}, {32'd0, out_q.pop_front()});
         end else begin
            check("out_zero", {32'd0, Out}, 64'd0);
         end
         if (Busy) begin
            if (run_len > 0 && (Start || MduOp == MTHI || MduOp == MTLO))
               fail("issue_while_busy");
            check("hilo_hold", {HI, LO}, held);
            run_len++;
         end else if (run_len > 0) begin
            if (len_q.size() == 0) fail("unexpected_busy");
            else check("busy_len", 64'(run_len), 64'(len_q.pop_front()));
            run_len = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_back();
      MduOp = MFHI;
      out_q.push_back(m_hilo[63:32]);
      tick();
      MduOp = MFLO;
      out_q.push_back(m_hilo[31:0]);
      tick();
      MduOp = MDU_NONE;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_hilo = 64'd0;
   endtask

   task automatic mt(input logic [3:0] op, input logic [31:0] a);
      MduOp = op;
      A = a;
      tick();
      MduOp = MDU_NONE;
      if (op == MTHI) m_hilo[63:32] = a;
      else m_hilo[31:0] = a;
      read_back();
   endtask

   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int rst_at = 0);
      int          blen;
      int          k;
      logic [63:0] nh;
      nh = m_hilo;
      held = m_hilo;
      model(op, a, b, nh, blen);
      Start = 1'b1;
      MduOp = op;
      A = a;
      B = b;
      len_q.push_back((rst_at > 0) ? rst_at : blen);
      tick();
      Start = 1'b0;
      MduOp = MDU_NONE;
      if (rst_at > 0) begin
         repeat (rst_at - 2) tick();
         do_reset();
         repeat (DIVN + 2) tick();
      end else begin
         k = 0;
         while (Busy && k < 40) begin
            tick();
            k++;
         end
         if (Busy) fail("busy_timeout");
         m_hilo = nh;
      end
      read_back();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  ops [10];
      int          nops;
      logic [3:0]  op;
      logic [31:0] ra, rb;
      ops = '{MULT, MULTU, DIV, DIVU, MTHI, MTLO, MADD, MADDU, MSUB, MSUBU};
`ifdef MDU_MADD_EN
      nops = 10;
`else
      nops = 6;
`endif
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      mon_en = 1'b1;
      read_back();

      mt(MTHI, 32'h1234_5678);
      do_reset();
      read_back();

      run_op(MULT,  32'hFFFF_FFFE, 32'd3);
      run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op(DIV,   32'hFFFF_FFF9, 32'd2);
      run_op(DIVU,  32'd7,         32'd0);
      run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF);
      run_op(DIV,   32'h0000_0011, 32'd0);
      run_op(DIV,   32'd12345,     32'd100, 3);

      mt(MTHI, 32'd0);
      mt(MTLO, 32'hFFFF_FFFF);
      run_op(MADDU, 32'd1, 32'd1);

      for (int i = 0; i < 40; i++) begin
         op = ops[$urandom_range(0, nops - 1)];
         ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) rb = $urandom_range(1, 9);
         if (op == MTHI || op == MTLO) mt(op, ra);
         else run_op(op, ra, rb);
      end

      repeat (3) tick();
      if (out_q.size() != 0) fail("pending_reads_left");
      if (len_q.size() != 0) fail("pending_busy_left");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
